pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline-boundary register that replaces the hard-wired stall/flush stage buffers with a valid/ready handshake and a two-entry skid buffer. It sits between any two pipeline stages, for example fetch→decode, and carries an opaque payload of DATA_W bits. It sustains one transfer per cycle with registered s_ready_o, so there is no combinational ready path from the downstream stage to the upstream stage. A synchronous flush turns the stage into a bubble.

Parameters:
- DATA_W, 96, payload width in bits (pc + pc_next + instruction = 3×32).
- RESET_DATA, '0, payload value presented on m_data_o after reset or flush.

Ports:
- ACLK  input  1  clock, rising edge.
- ARESETn  input  1  reset, asynchronous, active-low.
- flush_i  input  1  synchronous flush: discard all held entries.
- s_valid_i  input  1  upstream payload valid.
- s_ready_o  output  1  stage can accept a payload (registered).
- s_data_i  input  DATA_W  upstream payload.
- m_valid_o  output  1  downstream payload valid (registered).
- m_ready_i  input  1  downstream accepts the payload.
- m_data_o  output  DATA_W  downstream payload (registered, main entry).
- occupancy_o  output  2  number of held entries, 0..2.

Behaviour:
- Transfer definitions:
  - s_fire = s_valid_i & s_ready_o.
  - m_fire = m_valid_o & m_ready_i.
- Storage: main register (drives m_data_o) and skid register (internal).
- State encodes occupancy: EMPTY (0), ONE (1), TWO (2). occupancy_o equals the state.
- Outputs derived from the state register only:
  - m_valid_o = (state != EMPTY).
  - s_ready_o = (state != TWO).
- Reset (asynchronous, any time, including mid-transfer):
  - state = EMPTY, m_valid_o = 0, s_ready_o = 1, occupancy_o = 0.
  - main = skid = RESET_DATA.
  - Outputs take these values immediately on ARESETn low; release is synchronous to ACLK.
- Transitions when flush_i = 0:
  - EMPTY, s_fire → ONE; main ← s_data_i.
  - EMPTY, no s_fire → EMPTY; main unchanged.
  - ONE, s_fire & m_fire → ONE; main ← s_data_i (back-to-back streaming).
  - ONE, s_fire & !m_fire → TWO; skid ← s_data_i; main unchanged.
  - ONE, !s_fire & m_fire → EMPTY; main contents don't-care but left unchanged.
  - ONE, neither → ONE, hold.
  - TWO: s_ready_o = 0, so s_fire is impossible. On m_fire → ONE; main ← skid. Otherwise hold.
- Flush (flush_i = 1 at a rising edge):
  - Next state = EMPTY; main ← RESET_DATA; skid ← RESET_DATA.
  - Flush overrides any coincident s_fire (payload is dropped) and any coincident m_fire.
  - Upstream must treat a payload presented during a flush cycle with s_ready_o = 1 as consumed and discarded.
  - The downstream consumer sees that cycle's m_data_o as transferred if m_ready_i = 1. Pipeline control guarantees the consumer ignores it during the flush.
- Latency and throughput:
  - Latency is 1 cycle: an s_fire at edge N gives m_valid_o = 1 with that payload after edge N.
  - Throughput is 1 transfer per cycle while m_ready_i = 1.
  - Payload order is strictly FIFO. No payload is duplicated or lost except by flush.
- Stability rule: while m_valid_o = 1 and m_ready_i = 0, m_data_o and m_valid_o hold. m_valid_o never deasserts without m_fire, flush or reset.
- m_data_o is meaningful only when m_valid_o = 1. It reads RESET_DATA after reset or flush, until the first accepted payload.
- Assertions required in RTL (simulation only):
  - No s_fire while state == TWO.
  - occupancy_o ≤ 2.

Test Plan:
- Reset mid-stream: state TWO holding 0xA/0xB, pulse ARESETn low asynchronously mid-cycle → m_valid_o = 0, s_ready_o = 1, occupancy_o = 0, m_data_o = RESET_DATA immediately.
- Streaming: m_ready_i = 1, send 0x1..0x8 on consecutive cycles → 0x1..0x8 on m_data_o, each one cycle after input, m_valid_o continuously 1, s_ready_o never 0.
- Backpressure/skid: send 0x10, 0x11, 0x12 back-to-back with m_ready_i = 0 → occupancy 1 then 2, s_ready_o = 0 after the second transfer, 0x12 held upstream. Raise m_ready_i → outputs 0x10, 0x11, 0x12 in order, no loss.
- Flush with occupancy 2 (0x20/0x21) and a coincident s_valid_i = 1 carrying 0x22 → next cycle occupancy 0, m_valid_o = 0, m_data_o = RESET_DATA, 0x22 never appears.
- Drain to empty: occupancy 1 holding 0x30, m_ready_i = 1, s_valid_i = 0 → occupancy 0 next cycle. Then s_valid_i = 1 with 0x31 → m_valid_o = 1, m_data_o = 0x31 one cycle later.
- Random stress, 10k cycles with random s_valid_i, m_ready_i and 2% flush_i against a queue scoreboard → FIFO order exact, stability rule never violated, occupancy_o matches the model every cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with valid/ready handshake and a two-entry skid buffer.
// Both handshake outputs come from flops, so no ready path passes through combinationally.

module pipe_stage_skid_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       s_valid,
  input logic       s_ready,
  input logic [1:0] occupancy
);

  // A full stage must never accept a payload, and occupancy never exceeds two entries.
  no_fire_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(s_valid && s_ready && (occupancy == 2'd2)));
  occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= 2'd2);

endmodule

module pipe_stage_skid #(
  parameter int                 DATA_W     = 96,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_r;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] skid_r;
  logic              m_valid_r;
  logic              s_ready_r;
  logic              s_fire_s;
  logic              m_fire_s;

  assign s_fire_s = s_valid_i & s_ready_r;
  assign m_fire_s = m_valid_r & m_ready_i;

  // Occupancy FSM; m_valid_r/s_ready_r are loaded with the values implied by the next state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r   <= EMPTY;
      main_r    <= RESET_DATA;
      skid_r    <= RESET_DATA;
      m_valid_r <= 1'b0;
      s_ready_r <= 1'b1;
    end else if (flush_i) begin
      state_r   <= EMPTY;
      main_r    <= RESET_DATA;
      skid_r    <= RESET_DATA;
      m_valid_r <= 1'b0;
      s_ready_r <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (s_fire_s) begin
            state_r   <= ONE;
            main_r    <= s_data_i;
            m_valid_r <= 1'b1;
            s_ready_r <= 1'b1;
          end else begin
            state_r <= EMPTY;
          end
        end
        ONE: begin
          if (s_fire_s && m_fire_s) begin
            main_r <= s_data_i;
          end else if (s_fire_s) begin
            state_r   <= TWO;
            skid_r    <= s_data_i;
            s_ready_r <= 1'b0;
          end else if (m_fire_s) begin
            // Main keeps its stale contents; m_valid_o already marks it meaningless.
            state_r   <= EMPTY;
            m_valid_r <= 1'b0;
          end else begin
            state_r <= ONE;
          end
        end
        TWO: begin
          if (m_fire_s) begin
            state_r   <= ONE;
            main_r    <= skid_r;
            s_ready_r <= 1'b1;
          end else begin
            state_r <= TWO;
          end
        end
        default: begin
          state_r   <= EMPTY;
          main_r    <= RESET_DATA;
          skid_r    <= RESET_DATA;
          m_valid_r <= 1'b0;
          s_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready_o   = s_ready_r;
  assign m_valid_o   = m_valid_r;
  assign m_data_o    = main_r;
  assign occupancy_o = state_r;

  pipe_stage_skid_chk u_chk (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .s_valid   (s_valid_i),
    .s_ready   (s_ready_r),
    .occupancy (occupancy_o)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised self-checking bench for pipe_stage_skid.
// Inputs are driven 1 time unit after the rising edge, outputs are checked at the same point.

module tb_pipe_stage_skid;

  localparam int               DW      = 96;
  localparam logic [DW-1:0]    RST_VAL = 96'h0000_0000_0000_0000_DEAD_BEEF;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          flush_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic [1:0]    occupancy_o;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.DATA_W(DW), .RESET_DATA(RST_VAL)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .flush_i     (flush_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .occupancy_o (occupancy_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0; s_data_i = '0;
    #22;
    checks++;
    if ({m_valid_o, s_ready_o, occupancy_o} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b r=%b occ=%0d, want v=0 r=1 occ=0", m_valid_o, s_ready_o, occupancy_o);
    end
    checks++;
    if (m_data_o !== RST_VAL) begin
      errors++; $display("FAIL reset_data: got %h want %h", m_data_o, RST_VAL);
    end
    ARESETn = 1'b1;
    tick();
    // Fill to two entries, then reset asynchronously mid-cycle.
    s_valid_i = 1'b1; s_data_i = 96'hA; tick();
    s_data_i = 96'hB; tick();
    s_valid_i = 1'b0;
    checks++;
    if (occupancy_o !== 2'd2) begin
      errors++; $display("FAIL pre_reset_occ: got %0d want 2", occupancy_o);
    end
    #3 ARESETn = 1'b0;
    #1;
    checks++;
    if ({m_valid_o, s_ready_o, occupancy_o} !== 4'b0100) begin
      errors++;
      $display("FAIL async_reset_ctrl: got v=%b r=%b occ=%0d, want v=0 r=1 occ=0", m_valid_o, s_ready_o, occupancy_o);
    end
    checks++;
    if (m_data_o !== RST_VAL) begin
      errors++; $display("FAIL async_reset_data: got %h want %h", m_data_o, RST_VAL);
    end
    #2 ARESETn = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    m_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid_i = 1'b1; s_data_i = DW'(i);
      checks++;
      if (s_ready_o !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, s_ready_o);
      end
      tick();
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== DW'(i)) begin
        errors++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, m_valid_o, m_data_o, DW'(i));
      end
    end
    s_valid_i = 1'b0;
    tick();
    checks++;
    if (m_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      errors++; $display("FAIL stream_end: got v=%b occ=%0d want v=0 occ=0", m_valid_o, occupancy_o);
    end
  endtask

  task automatic test_backpressure();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 96'h10; tick();
    checks++;
    if (occupancy_o !== 2'd1 || s_ready_o !== 1'b1 || m_data_o !== 96'h10) begin
      errors++; $display("FAIL bp_one: got occ=%0d r=%b d=%h want occ=1 r=1 d=10", occupancy_o, s_ready_o, m_data_o);
    end
    s_data_i = 96'h11; tick();
    checks++;
    if (occupancy_o !== 2'd2 || s_ready_o !== 1'b0 || m_data_o !== 96'h10) begin
      errors++; $display("FAIL bp_two: got occ=%0d r=%b d=%h want occ=2 r=0 d=10", occupancy_o, s_ready_o, m_data_o);
    end
    s_data_i = 96'h12; tick();
    checks++;
    if (occupancy_o !== 2'd2 || m_valid_o !== 1'b1 || m_data_o !== 96'h10) begin
      errors++; $display("FAIL bp_hold: got occ=%0d v=%b d=%h want occ=2 v=1 d=10", occupancy_o, m_valid_o, m_data_o);
    end
    m_ready_i = 1'b1; tick();
    checks++;
    if (occupancy_o !== 2'd1 || s_ready_o !== 1'b1 || m_data_o !== 96'h11) begin
      errors++; $display("FAIL bp_drain1: got occ=%0d r=%b d=%h want occ=1 r=1 d=11", occupancy_o, s_ready_o, m_data_o);
    end
    tick();
    checks++;
    if (occupancy_o !== 2'd1 || m_data_o !== 96'h12) begin
      errors++; $display("FAIL bp_drain2: got occ=%0d d=%h want occ=1 d=12", occupancy_o, m_data_o);
    end
    s_valid_i = 1'b0; tick();
    checks++;
    if (occupancy_o !== 2'd0 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got occ=%0d v=%b want occ=0 v=0", occupancy_o, m_valid_o);
    end
  endtask

  task automatic test_flush();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 96'h20; tick();
    s_data_i = 96'h21; tick();
    s_data_i = 96'h22; flush_i = 1'b1; tick();
    flush_i = 1'b0; s_valid_i = 1'b0;
    checks++;
    if (occupancy_o !== 2'd0 || m_valid_o !== 1'b0 || s_ready_o !== 1'b1 || m_data_o !== RST_VAL) begin
      errors++;
      $display("FAIL flush_full: got occ=%0d v=%b r=%b d=%h want occ=0 v=0 r=1 d=%h", occupancy_o, m_valid_o, s_ready_o, m_data_o, RST_VAL);
    end
    m_ready_i = 1'b1; tick(); tick();
    checks++;
    if (m_valid_o !== 1'b0 || m_data_o === 96'h22) begin
      errors++; $display("FAIL flush_no_ghost: got v=%b d=%h want v=0 and no 22", m_valid_o, m_data_o);
    end
    // Flush beats a coincident accept into an empty stage.
    s_valid_i = 1'b1; s_data_i = 96'h23; flush_i = 1'b1; tick();
    flush_i = 1'b0; s_valid_i = 1'b0;
    checks++;
    if (occupancy_o !== 2'd0 || m_valid_o !== 1'b0 || m_data_o !== RST_VAL) begin
      errors++; $display("FAIL flush_vs_fire: got occ=%0d v=%b d=%h want occ=0 v=0 d=%h", occupancy_o, m_valid_o, m_data_o, RST_VAL);
    end
  endtask

  task automatic test_drain();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 96'h30; tick();
    s_valid_i = 1'b0; m_ready_i = 1'b1; tick();
    checks++;
    if (occupancy_o !== 2'd0 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got occ=%0d v=%b want occ=0 v=0", occupancy_o, m_valid_o);
    end
    s_valid_i = 1'b1; s_data_i = 96'h31; tick();
    s_valid_i = 1'b0;
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 96'h31) begin
      errors++; $display("FAIL drain_refill: got v=%b d=%h want v=1 d=31", m_valid_o, m_data_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          sf, mf;
    for (int c = 0; c < 10000; c++) begin
      checks++;
      if (occupancy_o !== 2'(q.size()) || m_valid_o !== (q.size() != 0) || s_ready_o !== (q.size() != 2)) begin
        errors++;
        $display("FAIL rnd_ctrl[%0d]: got occ=%0d v=%b r=%b want occ=%0d", c, occupancy_o, m_valid_o, s_ready_o, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (m_data_o !== q[0]) begin
          errors++; $display("FAIL rnd_data[%0d]: got %h want %h", c, m_data_o, q[0]);
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== prev_data) begin
          errors++; $display("FAIL rnd_stable[%0d]: got v=%b d=%h want v=1 d=%h", c, m_valid_o, m_data_o, prev_data);
        end
      end
      s_valid_i = 1'($urandom_range(0, 1));
      m_ready_i = 1'($urandom_range(0, 1));
      flush_i   = ($urandom_range(0, 99) < 2);
      s_data_i  = {$urandom, $urandom, $urandom};
      sf = s_valid_i && (q.size() != 2);
      mf = m_ready_i && (q.size() != 0);
      prev_stall = (q.size() != 0) && !m_ready_i && !flush_i;
      prev_data  = (q.size() != 0) ? q[0] : '0;
      if (flush_i) begin
        q.delete();
      end else begin
        if (mf) void'(q.pop_front());
        if (sf) q.push_back(s_data_i);
      end
      tick();
    end
    s_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
